// File: rtl/bru_pkg.sv
// Shared constants and helpers for the branch resolve unit: condition codes,
// predictor counter states and the saturating counter step.
package bru_pkg;

    localparam logic [3:0] BRU_NONE = 4'd0;
    localparam logic [3:0] BRU_EQ   = 4'd1;
    localparam logic [3:0] BRU_NE   = 4'd2;
    localparam logic [3:0] BRU_GTZ  = 4'd3;
    localparam logic [3:0] BRU_GEZ  = 4'd4;
    localparam logic [3:0] BRU_LTZ  = 4'd5;
    localparam logic [3:0] BRU_LEZ  = 4'd6;
    localparam logic [3:0] BRU_GE   = 4'd7;
    localparam logic [3:0] BRU_LT   = 4'd8;
    localparam logic [3:0] BRU_ULT  = 4'd9;
    localparam logic [3:0] BRU_UGE  = 4'd10;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bru_ctr_e;

    function automatic logic bru_is_branch(input logic [3:0] mode);
        return (mode >= BRU_EQ) && (mode <= BRU_UGE);
    endfunction

    function automatic logic [1:0] bru_ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == ST) ? ST : ctr + 2'd1;
        end else begin
            nxt = (ctr == SNT) ? SNT : ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bru_counter_table.sv
// Untagged DEPTH x 2-bit saturating predictor table: one combinational read
// port for fetch, one synchronous update port for resolved branches.
module bru_counter_table
    import bru_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int PC_LSB = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] rd_pc_i,
    output logic [1:0]  rd_ctr_o,
    input  logic        wr_en_i,
    input  logic [31:0] wr_pc_i,
    input  logic        wr_taken_i
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [1:0]       ctr_q [DEPTH];
    logic [1:0]       ctr_d;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;

    // Only the index slice of each PC matters; the rest is deliberately ignored.
    logic [31:0] unused_rd_pc;
    logic [31:0] unused_wr_pc;
    assign unused_rd_pc = rd_pc_i;
    assign unused_wr_pc = wr_pc_i;

    assign rd_idx = rd_pc_i[PC_LSB +: IDX_W];
    assign wr_idx = wr_pc_i[PC_LSB +: IDX_W];

    // Reads the registered array, so a same-cycle update is not visible yet.
    assign rd_ctr_o = ctr_q[rd_idx];
    assign ctr_d    = bru_ctr_next(ctr_q[wr_idx], wr_taken_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= WNT;
            end
        end else if (wr_en_i) begin
            ctr_q[wr_idx] <= ctr_d;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolve unit: condition evaluation, registered result stage
// and predictor update. Define BRU_PERF_CNT_EN to add branch/mispredict counters.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int PC_LSB = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [3:0]       cmp_mode,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic [31:0]      pc,
    input  logic             pred_in,
    input  logic [31:0]      fetch_pc,
    output logic             fetch_pred,
    output logic             out_valid,
    output logic             out_taken,
    output logic             out_mispredict,
    output logic [31:0]      out_pc
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]      perf_branches,
    output logic [31:0]      perf_mispredicts
`endif
);

    logic        cond;
    logic        is_br;
    logic        capture;
    logic        upd_en;
    logic [1:0]  fetch_ctr;

    logic        valid_q, valid_d;
    logic        taken_q, taken_d;
    logic        mis_q,   mis_d;
    logic [31:0] pc_q,    pc_d;

    always_comb begin
        cond = 1'b0;
        case (cmp_mode)
            BRU_EQ:  cond = (num1 == num2);
            BRU_NE:  cond = (num1 != num2);
            BRU_GTZ: cond = !num1[WIDTH-1] && (|num1);
            BRU_GEZ: cond = !num1[WIDTH-1];
            BRU_LTZ: cond = num1[WIDTH-1];
            BRU_LEZ: cond = num1[WIDTH-1] || !(|num1);
            BRU_GE:  cond = ($signed(num1) >= $signed(num2));
            BRU_LT:  cond = ($signed(num1) <  $signed(num2));
            BRU_ULT: cond = (num1 <  num2);
            BRU_UGE: cond = (num1 >= num2);
            default: cond = 1'b0;
        endcase
    end

    assign is_br   = bru_is_branch(cmp_mode);
    assign capture = in_valid && !stall && !flush;
    assign upd_en  = capture && is_br;

    // Flush outranks stall; an idle edge only drops valid.
    always_comb begin
        valid_d = valid_q;
        taken_d = taken_q;
        mis_d   = mis_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
            mis_d   = 1'b0;
        end else if (!stall) begin
            if (in_valid) begin
                valid_d = 1'b1;
                taken_d = cond;
                pc_d    = pc;
                mis_d   = is_br && (cond != pred_in);
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            taken_q <= 1'b0;
            mis_q   <= 1'b0;
            pc_q    <= 32'd0;
        end else begin
            valid_q <= valid_d;
            taken_q <= taken_d;
            mis_q   <= mis_d;
            pc_q    <= pc_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_taken      = taken_q;
    assign out_mispredict = mis_q;
    assign out_pc         = pc_q;

    bru_counter_table #(
        .DEPTH  (DEPTH),
        .PC_LSB (PC_LSB)
    ) u_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_pc_i    (fetch_pc),
        .rd_ctr_o   (fetch_ctr),
        .wr_en_i    (upd_en),
        .wr_pc_i    (pc),
        .wr_taken_i (cond)
    );

    assign fetch_pred = fetch_ctr[1];

`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_br_q,  perf_br_d;
    logic [31:0] perf_mis_q, perf_mis_d;

    // Counts follow table updates exactly; both wrap naturally at 2^32.
    always_comb begin
        perf_br_d  = perf_br_q;
        perf_mis_d = perf_mis_q;
        if (upd_en) begin
            perf_br_d = perf_br_q + 32'd1;
            if (cond != pred_in) begin
                perf_mis_d = perf_mis_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_br_q  <= 32'd0;
            perf_mis_q <= 32'd0;
        end else begin
            perf_br_q  <= perf_br_d;
            perf_mis_q <= perf_mis_d;
        end
    end

    assign perf_branches    = perf_br_q;
    assign perf_mispredicts = perf_mis_q;
`endif

endmodule
